// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor (A - B - borrow_in): one full-subtractor cell, LSB first, one bit per clock.
// Define SUB_OVERFLOW_FLAG_EN to add overflow_o, the signed two's-complement overflow of the result.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_in_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_out_o,
  output logic             valid_o,
  input  logic             ack_i,
`ifdef SUB_OVERFLOW_FLAG_EN
  output logic             overflow_o,
`endif
  output logic             busy_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Full-subtractor cell; returns {bout, diff}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
    logic d;
    logic bo;
    d  = a ^ b ^ bin;
    bo = (~a & b) | (~(a ^ b) & bin);
    return {bo, d};
  endfunction

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             cell_diff;
  logic             cell_bout;

  assign {cell_bout, cell_diff} = full_sub(a_sr[0], b_sr[0], borrow);

  assign diff_o       = diff_sr;
  assign borrow_out_o = borrow;

  // Sequencer and datapath: result bits enter at the MSB, so after WIDTH shifts bit 0 lands at the LSB.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      ready_o    <= 1'b1;
      valid_o    <= 1'b0;
      busy_o     <= 1'b0;
      a_sr       <= {WIDTH{1'b0}};
      b_sr       <= {WIDTH{1'b0}};
      diff_sr    <= {WIDTH{1'b0}};
      borrow     <= 1'b0;
      cnt        <= {CW{1'b0}};
`ifdef SUB_OVERFLOW_FLAG_EN
      overflow_o <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            a_sr    <= a_i;
            b_sr    <= b_i;
            borrow  <= borrow_in_i;
            cnt     <= {CW{1'b0}};
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
            state   <= RUN;
          end else begin
            ready_o <= 1'b1;
            state   <= IDLE;
          end
        end
        RUN: begin
          diff_sr <= {cell_diff, diff_sr[WIDTH-1:1]};
          borrow  <= cell_bout;
          a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
          if (cnt == LAST) begin
            cnt     <= {CW{1'b0}};
            busy_o  <= 1'b0;
            valid_o <= 1'b1;
            state   <= DONE;
`ifdef SUB_OVERFLOW_FLAG_EN
            // On the last bit the shift-register LSBs hold the operand MSBs.
            overflow_o <= (a_sr[0] != b_sr[0]) && (cell_diff != a_sr[0]);
`endif
          end else begin
            cnt   <= cnt + ONE;
            state <= RUN;
          end
        end
        DONE: begin
          if (ack_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state   <= IDLE;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          ready_o <= 1'b1;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed self-checking bench for serial_subtractor_ctrl (WIDTH=8); overflow test needs SUB_OVERFLOW_FLAG_EN.
module tb_serial_subtractor_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start;
  logic       ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic [7:0] diff;
  logic       borrow_out;
  logic       valid;
  logic       ack;
  logic       busy;
`ifdef SUB_OVERFLOW_FLAG_EN
  logic       overflow;
`endif

  int errors = 0;
  int checks = 0;

  serial_subtractor_ctrl #(.WIDTH(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .ready_o      (ready),
    .a_i          (a),
    .b_i          (b),
    .borrow_in_i  (bin),
    .diff_o       (diff),
    .borrow_out_o (borrow_out),
    .valid_o      (valid),
    .ack_i        (ack),
`ifdef SUB_OVERFLOW_FLAG_EN
    .overflow_o   (overflow),
`endif
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // Issue one operation and wait (bounded) for valid; lat is edges after accept, 0 on timeout.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin, output int lat);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, valid, busy, diff, borrow_out} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_init: rdy/vld/busy/diff/bo=%b/%b/%b/%h/%b want 1/0/0/00/0", ready, valid, busy, diff, borrow_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Get into RUN with a nonzero partial result, then reset between edges.
    @(negedge clk);
    a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, valid, busy, diff, borrow_out} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_async: rdy/vld/busy/diff/bo=%b/%b/%b/%h/%b want 1/0/0/00/0", ready, valid, busy, diff, borrow_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
  endtask

  task automatic test_basic();
    int lat;
    ack = 1'b1;
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({ready, busy, valid} !== 3'b010) begin
      errors++;
      $display("FAIL basic_run_flags: rdy/busy/vld=%b%b%b want 010", ready, busy, valid);
    end
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 8", lat);
    end
    checks++;
    if ({diff, borrow_out} !== {8'h1E, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: diff=%h bo=%b want 1e/0", diff, borrow_out);
    end
    @(negedge clk);
    checks++;
    if ({valid, ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL basic_pulse_end: vld/rdy/busy=%b%b%b want 010", valid, ready, busy);
    end
  endtask

  task automatic test_underflow();
    int lat;
    ack = 1'b1;
    run_op(8'h00, 8'h01, 1'b0, lat);
    checks++;
    if ({lat[7:0], diff, borrow_out} !== {8'd8, 8'hFF, 1'b1}) begin
      errors++;
      $display("FAIL underflow: lat=%0d diff=%h bo=%b want 8/ff/1", lat, diff, borrow_out);
    end
    @(negedge clk);
    run_op(8'h10, 8'h0F, 1'b1, lat);
    checks++;
    if ({lat[7:0], diff, borrow_out} !== {8'd8, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL borrow_in: lat=%0d diff=%h bo=%b want 8/00/0", lat, diff, borrow_out);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    ack = 1'b0;
    run_op(8'h33, 8'h44, 1'b0, lat);
    checks++;
    if ({lat[7:0], diff, borrow_out} !== {8'd8, 8'hEF, 1'b1}) begin
      errors++;
      $display("FAIL bp_result: lat=%0d diff=%h bo=%b want 8/ef/1", lat, diff, borrow_out);
    end
    for (int i = 0; i < 20; i++) begin
      start = (i % 2 == 0);
      a = 8'h01; b = 8'h02; bin = 1'b1;
      @(negedge clk);
      checks++;
      if ({valid, ready, busy, diff, borrow_out} !== {1'b1, 1'b0, 1'b0, 8'hEF, 1'b1}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: vld/rdy/busy=%b%b%b diff=%h bo=%b want 100/ef/1", i, valid, ready, busy, diff, borrow_out);
      end
    end
    start = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if ({valid, ready, busy, diff} !== {1'b0, 1'b1, 1'b0, 8'hEF}) begin
      errors++;
      $display("FAIL bp_release: vld/rdy/busy=%b%b%b diff=%h want 010/ef", valid, ready, busy, diff);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen;
    ack = 1'b1;
    @(negedge clk);
    a = 8'hFF; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_valid: got valid after abort, want none");
    end
    run_op(8'h03, 8'h05, 1'b0, lat);
    checks++;
    if ({lat[7:0], diff, borrow_out} !== {8'd8, 8'hFE, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_next: lat=%0d diff=%h bo=%b want 8/fe/1", lat, diff, borrow_out);
    end
    @(negedge clk);
  endtask

`ifdef SUB_OVERFLOW_FLAG_EN
  task automatic test_overflow();
    int lat;
    ack = 1'b1;
    run_op(8'h80, 8'h01, 1'b0, lat);
    checks++;
    if ({lat[7:0], diff, overflow} !== {8'd8, 8'h7F, 1'b1}) begin
      errors++;
      $display("FAIL ovf_set: lat=%0d diff=%h ovf=%b want 8/7f/1", lat, diff, overflow);
    end
    @(negedge clk);
    run_op(8'h7F, 8'h01, 1'b0, lat);
    checks++;
    if ({lat[7:0], diff, overflow} !== {8'd8, 8'h7E, 1'b0}) begin
      errors++;
      $display("FAIL ovf_clear: lat=%0d diff=%h ovf=%b want 8/7e/0", lat, diff, overflow);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    start = 1'b0;
    ack   = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    bin   = 1'b0;
    test_reset();
    test_basic();
    test_underflow();
    test_backpressure();
    test_reset_mid();
`ifdef SUB_OVERFLOW_FLAG_EN
    test_overflow();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Sequencer that performs WIDTH-bit subtraction (A - B - borrow_in) by time-multiplexing a single 1-bit full_subtractor cell, LSB first, one bit per clock. It sits between a requester that supplies operands and a consumer that takes the result. It trades WIDTH cycles of latency for one subtractor cell of area, which suits the tile budget.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk_i  input  1  clock, rising-edge
rst_ni  input  1  reset; one clock; reset is asynchronous and active-low
start_i  input  1  request: operands valid this cycle
ready_o  output  1  controller idle, can accept start_i
a_i  input  WIDTH  minuend, sampled on accept
b_i  input  WIDTH  subtrahend, sampled on accept
borrow_in_i  input  1  initial borrow, sampled on accept
diff_o  output  WIDTH  difference result, stable while valid_o
borrow_out_o  output  1  final borrow out of MSB, stable while valid_o
valid_o  output  1  result available
ack_i  input  1  consumer accepts result
busy_o  output  1  high in RUN state

Behaviour:
- Reset (rst_ni low, async): state=IDLE; ready_o=1, valid_o=0, busy_o=0, diff_o=0, borrow_out_o=0, internal bit counter=0, borrow flop=0, operand shift registers=0.
- Datapath: one full_subtractor cell. Its a input is the LSB of the A shift register, its b input is the LSB of the B shift register, and its borrow input is the borrow flop. Cell function: diff = a^b^bin, bout = (~a&b) | (~(a^b)&bin).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready_o=1.
  - Accept on a rising edge where start_i=1. On accept, load A<-a_i, B<-b_i, borrow flop<-borrow_in_i, counter<-0, and go to RUN.
  - With start_i=0, stay in IDLE.
- RUN (busy_o=1, ready_o=0), each edge:
  - Shift the cell diff into the result register MSB, right-shifting the result.
  - Borrow flop <- cell bout.
  - Right-shift A and B.
  - counter++.
  - On the edge where counter==WIDTH-1, go to DONE.
- start_i is ignored outside IDLE. Operand inputs are ignored after the accept edge.
- Latency: the accept edge is E0. Bits are processed on edges E1..E_WIDTH. valid_o is high after E_WIDTH, so the result is available WIDTH cycles after accept.
- DONE:
  - valid_o=1; diff_o and borrow_out_o (the borrow flop) are held stable.
  - Leave on an edge with ack_i=1, then go to IDLE with valid_o=0 and ready_o=1 the next cycle.
  - ack_i held low means hold indefinitely (backpressure).
  - diff_o and borrow_out_o keep their last values in IDLE until the next result overwrites them.
- ack_i outside DONE: ignored.
- Back-to-back: the minimum initiation interval is WIDTH+2 cycles (accept, WIDTH bits, ack cycle, next accept).
- Arithmetic: diff_o = (a_i - b_i - borrow_in_i) mod 2^WIDTH. borrow_out_o=1 if and only if a_i < b_i + borrow_in_i (unsigned).
- Reset mid-RUN or mid-DONE: abort immediately to reset values. The partial result is discarded and no valid_o pulse is produced.
- Counter width: $clog2(WIDTH); it must not wrap before WIDTH-1.

Optional Feature:
Macro SUB_OVERFLOW_FLAG_EN.
- When defined:
  - Adds output port overflow_o (1 bit), reset value 0.
  - Set in DONE to the signed two's-complement overflow of the operation: (a_msb != b_msb) && (diff_msb != a_msb), where a_msb and b_msb are the operand MSBs captured during the final RUN bit.
  - Valid and stable while valid_o=1; cleared on reset only.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use WIDTH=8.
1. Reset: rst_ni=0 asynchronously mid-cycle -> ready_o=1, valid_o=0, busy_o=0, diff_o=0x00, borrow_out_o=0 immediately, without waiting for a clock edge.
2. Basic subtraction: a=0x5A, b=0x3C, bin=0, ack_i tied 1 -> valid_o rises exactly 8 cycles after accept, diff_o=0x1E, borrow_out_o=0, one-cycle valid pulse, then ready_o=1.
3. Underflow and initial borrow: a=0x00, b=0x01, bin=0 -> diff_o=0xFF, borrow_out_o=1. Then a=0x10, b=0x0F, bin=1 -> diff_o=0x00, borrow_out_o=0.
4. Backpressure: ack_i=0 for 20 cycles after valid_o -> valid_o, diff_o and borrow_out_o stable throughout; start_i pulses in DONE ignored; ack_i=1 -> IDLE next cycle.
5. Reset mid-operation: assert rst_ni=0 at RUN bit 4 with a=0xFF, b=0x01, then release and issue a=0x03, b=0x05 -> no valid_o from the first operation; the second gives diff_o=0xFE, borrow_out_o=1.
6. SUB_OVERFLOW_FLAG_EN defined: a=0x80, b=0x01 -> diff_o=0x7F, overflow_o=1. a=0x7F, b=0x01 -> diff_o=0x7E, overflow_o=0.
